// File: rtl/synth_frame_loader_pkg.sv
// Shared frame protocol types: synth_t control word, frame FSM states, sizes.
// SYNTH_FRAME_CHECKSUM_EN selects the checksummed frame format.
package synth_frame_loader_pkg;

    localparam int NUM_WAVE_GENS = 2;

    typedef enum logic [1:0] {
        WAVE_SQR = 2'd0,
        WAVE_SAW = 2'd1,
        WAVE_SIN = 2'd2,
        WAVE_TRI = 2'd3
    } wave_shape_t;

    typedef struct packed {
        wave_shape_t shape;
        logic [15:0] freq;
    } wave_gen_t;

    typedef struct packed {
        logic [7:0] attack;
        logic [7:0] rel;
    } env_t;

    typedef struct packed {
        wave_gen_t [NUM_WAVE_GENS-1:0] wave_gens;
        env_t                          env;
        logic [7:0]                    echo_mix;
        logic [7:0]                    reverb_mix;
        logic [5:0]                    looper_ctrl;
        logic [7:0]                    pan;
        logic [31:0]                   volume;
    } synth_t;

    localparam int SYNTH_BITS          = $bits(synth_t);
    localparam int SYNTH_PAYLOAD_BYTES = (SYNTH_BITS + 7) / 8;
    localparam int FRAME_CNT_W         = $clog2(SYNTH_PAYLOAD_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHECK,
        DONE,
        DISCARD
    } frame_state_t;

    function automatic synth_t synth_reset();
        synth_t s;
        s = '0;
        for (int i = 0; i < NUM_WAVE_GENS; i++) begin
            s.wave_gens[i].shape = WAVE_SIN;
        end
        return s;
    endfunction

endpackage

// File: rtl/synth_frame_loader_xor_checksum.sv
// Running XOR accumulator over frame payload bytes, with clear and enable.
// Instantiated only when SYNTH_FRAME_CHECKSUM_EN is defined.
module frame_xor_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_csum
);

    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_csum <= '0;
        end else if (i_en) begin
            r_csum <= r_csum ^ i_byte;
        end
    end

    assign o_csum = r_csum;

endmodule

// File: rtl/synth_frame_loader.sv
// Serial byte frame decoder committing synth_t atomically on valid frames.
// Define SYNTH_FRAME_CHECKSUM_EN to append and verify an XOR checksum byte.
module synth_frame_loader
    import synth_frame_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h5A,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_active,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output synth_t               synth_out,
    output logic                 synth_commit,
    output logic                 err_sync,
    output logic                 err_len,
    output logic                 err_csum,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam logic [FRAME_CNT_W-1:0] LAST_CNT =
        FRAME_CNT_W'(SYNTH_PAYLOAD_BYTES - 1);

`ifdef SYNTH_FRAME_CHECKSUM_EN
    localparam frame_state_t AFTER_LOAD = CHECK;
`else
    localparam frame_state_t AFTER_LOAD = DONE;
`endif

    frame_state_t           r_state;
    logic                   r_fa_d;
    logic [SYNTH_BITS-1:0]  r_shadow;
    logic [FRAME_CNT_W-1:0] r_cnt;
    synth_t                 r_synth;
    logic                   r_commit_pend;
    logic                   r_commit;
    logic                   r_err_sync;
    logic                   r_err_len;
    logic                   r_err_csum;
    logic [ERR_CNT_W-1:0]   r_err_count;

    logic w_byte;
    logic w_rise;
    logic w_sync_ok;
    logic w_err_sync;
    logic w_err_len;
    logic w_err_csum;
    logic w_err_any;
    logic w_load_last;

    assign w_byte      = byte_valid && frame_active;
    assign w_rise      = frame_active && !r_fa_d;
    assign w_sync_ok   = w_byte && (byte_in == SYNC_BYTE);
    assign w_load_last = (r_cnt == LAST_CNT);

    assign w_err_sync = (r_state == HDR) && w_byte && (byte_in != SYNC_BYTE);
    assign w_err_len  = ((r_state == LOAD || r_state == CHECK) && !frame_active)
                     || ((r_state == DONE) && w_byte);

`ifdef SYNTH_FRAME_CHECKSUM_EN
    logic [7:0] w_csum;
    logic       w_csum_clr;
    logic       w_csum_en;

    assign w_csum_clr = (r_state == HDR) && w_sync_ok;
    assign w_csum_en  = (r_state == LOAD) && w_byte;
    assign w_err_csum = (r_state == CHECK) && w_byte && (byte_in != w_csum);

    frame_xor_checksum u_csum (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_csum_clr),
        .i_en   (w_csum_en),
        .i_byte (byte_in),
        .o_csum (w_csum)
    );
`else
    assign w_err_csum = 1'b0;
`endif

    assign w_err_any = w_err_sync || w_err_len || w_err_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            // Chip select held through reset must not look like a new frame
            r_fa_d        <= frame_active;
            r_shadow      <= '0;
            r_cnt         <= '0;
            r_synth       <= synth_reset();
            r_commit_pend <= 1'b0;
            r_commit      <= 1'b0;
            r_err_sync    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_fa_d        <= frame_active;
            r_commit      <= r_commit_pend;
            r_commit_pend <= 1'b0;
            r_err_sync    <= w_err_sync;
            r_err_len     <= w_err_len;
            r_err_csum    <= w_err_csum;

            if (r_commit_pend) begin
                r_synth <= synth_t'(r_shadow);
            end

            if (w_err_any && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_sync_ok) begin
                        r_cnt   <= '0;
                        r_state <= LOAD;
                    end else if (w_byte) begin
                        r_state <= DISCARD;
                    end else if (!frame_active) begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    if (!frame_active) begin
                        r_state <= IDLE;
                    end else if (w_byte) begin
                        // Shadow is synth_t wide, so leading pad bits fall off
                        r_shadow <= {r_shadow[SYNTH_BITS-9:0], byte_in};
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_load_last) begin
                            r_state <= AFTER_LOAD;
                        end
                    end
                end
`ifdef SYNTH_FRAME_CHECKSUM_EN
                CHECK: begin
                    if (!frame_active) begin
                        r_state <= IDLE;
                    end else if (w_byte) begin
                        r_state <= w_err_csum ? DISCARD : DONE;
                    end
                end
`endif
                DONE: begin
                    if (!frame_active) begin
                        r_commit_pend <= 1'b1;
                        r_state       <= IDLE;
                    end else if (w_byte) begin
                        r_state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (!frame_active) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign synth_out    = r_synth;
    assign synth_commit = r_commit;
    assign err_sync     = r_err_sync;
    assign err_len      = r_err_len;
    assign err_csum     = r_err_csum;
    assign err_count    = r_err_count;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_synth_frame_loader.sv
// Scoreboard bench for synth_frame_loader: directed frames, queued expectations.
// Follows SYNTH_FRAME_CHECKSUM_EN to build checksummed or plain frames.
module tb_synth_frame_loader;
    import synth_frame_loader_pkg::*;

    localparam int PB = SYNTH_PAYLOAD_BYTES;

    typedef enum int {M_GOOD, M_SHORT, M_BADSYNC, M_BADCSUM, M_OVERRUN} mode_t;

    typedef struct {
        int     kind;
        synth_t val;
        int     cnt;
        int     at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_active;
    logic [7:0] byte_in;
    logic       byte_valid;
    synth_t     synth_out;
    logic       synth_commit;
    logic       err_sync;
    logic       err_len;
    logic       err_csum;
    logic [7:0] err_count;
    logic       busy;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    int  exp_cnt = 0;
    ev_t q[$];

    synth_frame_loader dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .synth_out    (synth_out),
        .synth_commit (synth_commit),
        .err_sync     (err_sync),
        .err_len      (err_len),
        .err_csum     (err_csum),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin : mon
        int  k;
        int  np;
        ev_t e;
        if (!rst && (synth_commit || err_sync || err_len || err_csum)) begin
            np = int'(synth_commit) + int'(err_sync)
               + int'(err_len) + int'(err_csum);
            k  = synth_commit ? 0 : err_sync ? 1 : err_len ? 2 : 3;
            check("one_pulse", np, 1);
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                         k, cyc);
            end else begin
                e = q.pop_front();
                check("ev_kind", k, e.kind);
                check("ev_cycle", cyc, e.at);
                check("ev_err_count", err_count, e.cnt);
                if (e.kind == 0) begin
                    check("commit_value", synth_out, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input synth_t v, input int at);
        ev_t e;
        if (kind != 0) begin
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        end
        e.kind = kind;
        e.val  = v;
        e.cnt  = exp_cnt;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        check(nm, q.size(), 0);
        q.delete();
    endtask

    function automatic logic [PB*8-1:0] mkpay(input synth_t s, input bit pad1);
        logic [PB*8-1:0] p;
        p = {(PB*8){pad1}};
        p[SYNTH_BITS-1:0] = s;
        return p;
    endfunction

    task automatic frame(input synth_t s, input mode_t mode, input bit pad1,
                         input string nm);
        logic [PB*8-1:0] p;
        logic [7:0]      cs;
        logic [7:0]      b;
        int              n;
        p  = mkpay(s, pad1);
        cs = 8'h00;
        frame_active = 1'b1;
        tick();
        if (mode == M_BADSYNC) begin
            push(1, '0, cyc + 1);
            send(8'h00);
        end else begin
            send(8'h5A);
        end
        n = (mode == M_SHORT) ? PB - 1 : PB;
        for (int i = 0; i < n; i++) begin
            b  = p[(PB-1-i)*8 +: 8];
            cs = cs ^ b;
            send(b);
        end
`ifdef SYNTH_FRAME_CHECKSUM_EN
        if (mode == M_GOOD || mode == M_OVERRUN) begin
            send(cs);
        end else if (mode == M_BADCSUM) begin
            push(3, '0, cyc + 1);
            send(cs ^ 8'h01);
        end
`endif
        if (mode == M_OVERRUN) begin
            push(2, '0, cyc + 1);
            send(8'hA5);
        end
        frame_active = 1'b0;
        if (mode == M_GOOD) begin
            push(0, s, cyc + 2);
        end else if (mode == M_SHORT) begin
            push(2, '0, cyc + 1);
        end
        repeat (3) tick();
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin : stim
        synth_t s1;
        synth_t s2;
        synth_t t;
        logic [PB*8-1:0] p;

        rst          = 1'b1;
        frame_active = 1'b0;
        byte_valid   = 1'b0;
        byte_in      = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < NUM_WAVE_GENS; i++) begin
            check("rst_shape", synth_out.wave_gens[i].shape, 2);
        end
        t = synth_out;
        for (int i = 0; i < NUM_WAVE_GENS; i++) begin
            t.wave_gens[i].shape = WAVE_SQR;
        end
        check("rst_other_zero", t, '0);
        check("rst_commit", synth_commit, 0);
        check("rst_errs", {err_sync, err_len, err_csum}, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);

        s1 = '0;
        s1.volume = 32'h0000_1234;
        frame(s1, M_GOOD, 1'b0, "valid_drain");
        check("valid_volume", synth_out.volume, 32'h1234);

        frame(s1, M_SHORT, 1'b0, "short_drain");
        check("short_keep", synth_out, s1);
        check("short_count", err_count, 1);

        s2 = '0;
        s2.wave_gens[0].shape = WAVE_TRI;
        s2.wave_gens[0].freq  = 16'hA55A;
        s2.wave_gens[1].shape = WAVE_SAW;
        s2.wave_gens[1].freq  = 16'h0102;
        s2.env.attack         = 8'h11;
        s2.env.rel            = 8'hEE;
        s2.echo_mix           = 8'h33;
        s2.reverb_mix         = 8'h44;
        s2.looper_ctrl        = 6'h2B;
        s2.pan                = 8'h80;
        s2.volume             = 32'hDEAD_BEEF;

        frame(s2, M_BADSYNC, 1'b0, "badsync_drain");
        check("badsync_keep", synth_out, s1);
        check("badsync_count", err_count, 2);

`ifdef SYNTH_FRAME_CHECKSUM_EN
        frame(s2, M_BADCSUM, 1'b0, "badcsum_drain");
        check("badcsum_keep", synth_out, s1);
`endif

        frame(s2, M_OVERRUN, 1'b0, "overrun_drain");
        check("overrun_keep", synth_out, s1);

        // Pad bits set to ones must not leak into the committed word
        frame(s2, M_GOOD, 1'b1, "pad_drain");
        check("pad_value", synth_out, s2);

        for (int i = 0; i < 260; i++) begin
            frame_active = 1'b1;
            tick();
            push(1, '0, cyc + 1);
            send(8'h00);
            frame_active = 1'b0;
            tick();
        end
        drain("sat_drain");
        check("sat_count", err_count, 255);

        p = mkpay(s1, 1'b0);
        frame_active = 1'b1;
        tick();
        send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            send(p[(PB-1-i)*8 +: 8]);
        end
        check("midload_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("midrst_shape0", synth_out.wave_gens[0].shape, 2);
        check("midrst_volume", synth_out.volume, 0);
        check("midrst_count", err_count, 0);
        check("midrst_busy", busy, 0);
        for (int i = 5; i < PB; i++) begin
            send(p[(PB-1-i)*8 +: 8]);
        end
        send(8'h00);
        frame_active = 1'b0;
        repeat (3) tick();
        check("midrst_ignored_busy", busy, 0);
        drain("midrst_drain");

        frame(s1, M_GOOD, 1'b0, "after_rst_drain");
        check("after_rst_value", synth_out, s1);
        check("after_rst_count", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/synth_frame_loader.md
# synth_frame_loader

Byte-level frame decoder between the MCU serial receiver (SPI slave byte output) and every consumer of the `synth_t` control word (wave generators, envelopes, echo, reverb, looper, pan, volume). Assembles one synchronised, length-checked frame into a shadow register. Commits the frame atomically to a registered `synth_t` output only when the frame is complete and valid. A malformed or partial frame never disturbs the live parameters.

## Interface
- `SYNC_BYTE`, default 8'h5A: first byte of every frame.
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `frame_active` input 1: chip select from the serial receiver, active-high. The high interval delimits one frame.
- `byte_in` input 8: received byte.
- `byte_valid` input 1: one-cycle strobe; `byte_in` is valid.
- `synth_out` output `$bits(synth_t)`: live parameter word, registered.
- `synth_commit` output 1: one-cycle pulse, coincident with the first cycle in which `synth_out` shows a new frame.
- `err_sync` output 1: one-cycle pulse; first byte was not `SYNC_BYTE`.
- `err_len` output 1: one-cycle pulse; frame was short or overran.
- `err_csum` output 1: one-cycle pulse; checksum mismatch. Only present in behaviour when the checksum feature is compiled in.
- `err_count` output `ERR_CNT_W`: saturating count of all error pulses.
- `busy` output 1: high in any state except IDLE.

## Operation
- Payload length `PAYLOAD_BYTES` = ceil(`$bits(synth_t)`/8).
- Payload is sent MSB first and shifted into a shadow register: `shadow <= {shadow, byte_in}`.
- On commit, `synth_out` takes the low `$bits(synth_t)` bits of the shadow register. Leading pad bits in the first payload byte are discarded.
- A `byte_valid` with `frame_active` low is ignored.
- States:
  - IDLE: on a rising edge of `frame_active` (high now, low in the previous cycle), go to HDR.
  - HDR: on a byte equal to `SYNC_BYTE`, clear the counter and checksum, then go to LOAD. On any other byte, pulse `err_sync` and go to DISCARD. If `frame_active` falls with no byte received, return to IDLE silently.
  - LOAD: each byte is shifted in, `cnt++`, and `csum ^= byte`. The byte that makes `cnt == PAYLOAD_BYTES` moves to CHECK if the checksum is compiled in, otherwise to DONE.
  - CHECK: next byte equals `csum`, go to DONE. Otherwise pulse `err_csum` and go to DISCARD.
  - DONE: any further byte pulses `err_len` (overrun) and goes to DISCARD. When `frame_active` falls, commit and go to IDLE.
  - DISCARD: ignore bytes; when `frame_active` falls, go to IDLE.
- `frame_active` falling in LOAD or CHECK pulses `err_len`, returns to IDLE, and does not commit.
- `err_count` increments by 1 per error pulse and saturates at all-ones.
- Reset values:
  - `synth_out` equals the result of the package reset function: every `wave_gens[i].shape` = SIN (2), all other fields 0.
  - All pulses 0, `err_count` 0, `busy` 0, state IDLE, shadow and checksum 0.
- Reset mid-frame: state returns to IDLE and `synth_out` returns to its defaults. `frame_active` still high after reset is not a rising edge, so the remainder of that frame is ignored.

## Timing
- A byte is consumed on the same edge at which `byte_valid` is sampled high. Maximum rate is one byte per cycle.
- Commit latency: `frame_active` sampled low in DONE at edge N. At edge N+1, `synth_out` updates and `synth_commit` = 1 for exactly one cycle.
- Error pulses are registered and appear one cycle after the offending byte or edge.
- `err_count` reflects an error in the same cycle as its pulse.
- Outside a commit, `synth_out` is stable, so downstream logic may sample it at any time.

## Configuration
- `SYNTH_FRAME_CHECKSUM_EN` defined:
  - Frame = `SYNC_BYTE` + `PAYLOAD_BYTES` payload + 1 checksum byte, where the checksum is the XOR of all payload bytes.
  - CHECK state exists and `err_csum` is functional.
- Not defined:
  - Frame = `SYNC_BYTE` + `PAYLOAD_BYTES`.
  - CHECK state is absent and `err_csum` is tied to 0.

## Structure
- Shared protocol package holds:
  - `SYNTH_PAYLOAD_BYTES` localparam derived from `$bits(synth_t)`.
  - The `frame_state_t` enum (IDLE, HDR, LOAD, CHECK, DONE, DISCARD).
  - The existing `synth_t` typedef and its reset function, reused for the reset value.
- One sub-module: `frame_xor_checksum`. It is the running XOR accumulator with clear and enable, instantiated only under `SYNTH_FRAME_CHECKSUM_EN`.

## Test plan
- Reset: `synth_out.wave_gens[i].shape` == 2 for all i, every other field 0; `synth_commit` = 0; `err_count` = 0.
- Valid frame:
  - Stimulus: 0x5A, then a payload with `volume` = 32'h0000_1234 and all else 0, then the correct checksum.
  - Response: `synth_out.volume` == 32'h1234 and one `synth_commit` pulse, exactly 1 cycle after `frame_active` falls.
- Short frame: 0x5A + (`PAYLOAD_BYTES`-1) bytes, then deassert -> `err_len` pulse, `synth_out` unchanged, `err_count` == 1.
- Bad sync: first byte 0x00, then a full payload -> `err_sync` pulse, no commit, trailing bytes ignored.
- Checksum and overrun:
  - Valid frame with checksum byte XOR 0x01 -> `err_csum`, no commit.
  - Valid frame plus one extra byte -> `err_len`, no commit.
  - With the macro undefined, the valid frame minus the checksum byte commits.
- Reset mid-LOAD, then remaining bytes, deassert, then one full valid frame -> no error pulses or commit from the first frame; second frame commits.
